pixel_coord_tagger: RTL and testbench

- Sits directly downstream of the 128-to-8-bit phrase unstacker on the frame-buffer read path.
- Consumes its 8-bit pixel AXI-stream, whose tlast marks the last pixel of a frame.
- Tags each pixel with hcount/vcount plus start-of-frame and end-of-line flags for the depth-mapping pipeline.
- Checks frame length against tlast, resynchronises on mismatch, and decouples backpressure through a 2-entry skid buffer.

---
 rtl/pixel_coord_tagger.sv | 180 ++++++++++++++++++
 tb/tb_pixel_coord_tagger.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_coord_tagger.sv
// Tags an 8-bit pixel AXI-stream with column/row coordinates and frame flags.
// It checks frame length against tlast, resynchronises on mismatch, and buffers output through a 2-entry skid.
`timescale 1ns/1ps

module pixel_coord_tagger #(
    parameter int H_PIXELS = 320,
    parameter int V_PIXELS = 180,
    parameter int HW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1,
    parameter int VW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          pixel_tvalid,
    output logic          pixel_tready,
    input  logic [7:0]    pixel_tdata,
    input  logic          pixel_tlast,
    output logic          out_tvalid,
    input  logic          out_tready,
    output logic [7:0]    out_tdata,
    output logic [HW-1:0] out_hcount,
    output logic [VW-1:0] out_vcount,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_tlast,
    output logic          frame_done,
    output logic          sync_error,
    output logic [15:0]   error_count
);

    typedef enum logic {RUN, RESYNC} state_t;

    typedef struct packed {
        logic [7:0]    data;
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        logic          sof;
        logic          eol;
        logic          last;
    } entry_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          done_d, err_d;
    logic          wr_en, wr_last;
    entry_t        wr_entry;

    entry_t        main_q, main_d, skid_q, skid_d;
    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;

    logic          accept, pop, at_h_end, at_v_end;

    // Ready depends only on flops; out_tready never reaches pixel_tready.
    assign pixel_tready = !rst_in && (state_q == RESYNC || !skid_valid_q);
    assign accept       = pixel_tvalid && pixel_tready;
    assign pop          = main_valid_q && out_tready;
    assign at_h_end     = (h_q == HW'(H_PIXELS - 1));
    assign at_v_end     = (v_q == VW'(V_PIXELS - 1));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (pixel_tlast) begin
                        wr_last = 1'b1;
                        h_d     = '0;
                        v_d     = '0;
                        if (at_h_end && at_v_end) done_d = 1'b1;
                        else                      err_d  = 1'b1;
                    end else if (at_h_end && at_v_end) begin
                        // Frame overran: close it here and discard input up to the stray tlast.
                        wr_last = 1'b1;
                        h_d     = '0;
                        v_d     = '0;
                        err_d   = 1'b1;
                        state_d = RESYNC;
                    end else if (at_h_end) begin
                        h_d = '0;
                        v_d = v_q + VW'(1);
                    end else begin
                        h_d = h_q + HW'(1);
                    end
                end
            end
            RESYNC: begin
                if (accept && pixel_tlast) begin
                    state_d = RUN;
                    h_d     = '0;
                    v_d     = '0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wr_entry.data = pixel_tdata;
        wr_entry.h    = h_q;
        wr_entry.v    = v_q;
        wr_entry.sof  = (h_q == '0) && (v_q == '0);
        wr_entry.eol  = at_h_end;
        wr_entry.last = wr_last;
    end

    // The skid entry is always older than any new write, so it moves to main first.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = wr_en;
                if (wr_en) skid_d = wr_entry;
            end else begin
                main_valid_d = wr_en;
                if (wr_en) main_d = wr_entry;
            end
        end else if (wr_en) begin
            skid_d       = wr_entry;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= RUN;
            h_q          <= '0;
            v_q          <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            frame_done   <= 1'b0;
            sync_error   <= 1'b0;
            error_count  <= '0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            v_q          <= v_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            frame_done   <= done_d;
            sync_error   <= err_d;
            if (err_d && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        end
    end

    // NOTE: buffer payload is not reset; the valid flags alone say whether it means anything.
    always_ff @(posedge clk_in) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign out_tvalid = main_valid_q;
    assign out_tdata  = main_q.data;
    assign out_hcount = main_q.h;
    assign out_vcount = main_q.v;
    assign out_sof    = main_q.sof;
    assign out_eol    = main_q.eol;
    assign out_tlast  = main_q.last;

    a_pulse_exclusive: assert property (@(posedge clk_in) disable iff (rst_in)
        !(frame_done && sync_error));

    a_stall_hold: assert property (@(posedge clk_in) disable iff (rst_in)
        (out_tvalid && !out_tready) |=> (out_tvalid && $stable(main_q)));

endmodule

// File: tb/tb_pixel_coord_tagger.sv
// Self-checking bench for pixel_coord_tagger (H=4, V=2): a per-cycle frame-position model
// plus directed checks on the logged output transfers.
`timescale 1ns/1ps

module tb_pixel_coord_tagger;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int HW = $clog2(H);
    localparam int VW = $clog2(V);

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          pixel_tvalid;
    logic          pixel_tready;
    logic [7:0]    pixel_tdata;
    logic          pixel_tlast;
    logic          out_tvalid;
    logic          out_tready;
    logic [7:0]    out_tdata;
    logic [HW-1:0] out_hcount;
    logic [VW-1:0] out_vcount;
    logic          out_sof;
    logic          out_eol;
    logic          out_tlast;
    logic          frame_done;
    logic          sync_error;
    logic [15:0]   error_count;

    pixel_coord_tagger #(.H_PIXELS(H), .V_PIXELS(V)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pixel_tvalid (pixel_tvalid),
        .pixel_tready (pixel_tready),
        .pixel_tdata  (pixel_tdata),
        .pixel_tlast  (pixel_tlast),
        .out_tvalid   (out_tvalid),
        .out_tready   (out_tready),
        .out_tdata    (out_tdata),
        .out_hcount   (out_hcount),
        .out_vcount   (out_vcount),
        .out_sof      (out_sof),
        .out_eol      (out_eol),
        .out_tlast    (out_tlast),
        .frame_done   (frame_done),
        .sync_error   (sync_error),
        .error_count  (error_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int data;
        int h;
        int v;
        bit sof;
        bit eol;
        bit last;
    } pix_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: linear position within the frame; coordinates follow from division.
    pix_t exp_q[$];
    pix_t log_q[$];
    int   pos = 0;
    bit   resync = 0;
    int   model_cnt = 0;
    bit   exp_done, exp_err;
    bit   acc_prev = 0, pop_prev = 0;
    int   acc_data;
    bit   acc_last;
    int   done_seen = 0, serr_seen = 0, ready_low_cnt = 0;

    task automatic model_accept(input int d, input bit l);
        pix_t p;
        bit   at_end;
        if (resync) begin
            if (l) begin
                resync = 0;
                pos    = 0;
            end
            return;
        end
        at_end = (pos == H * V - 1);
        p.data = d;
        p.h    = pos % H;
        p.v    = pos / H;
        p.sof  = (pos == 0);
        p.eol  = (pos % H == H - 1);
        p.last = l || at_end;
        exp_q.push_back(p);
        if (l) begin
            pos = 0;
            if (at_end) exp_done = 1;
            else        exp_err  = 1;
        end else if (at_end) begin
            pos    = 0;
            exp_err = 1;
            resync = 1;
        end else begin
            pos++;
        end
        if (exp_err && model_cnt < 65535) model_cnt++;
    endtask

    always @(negedge clk_in) begin
        if (rst_in) begin
            exp_q.delete();
            pos       = 0;
            resync    = 0;
            model_cnt = 0;
            acc_prev  = 0;
            pop_prev  = 0;
            check("rst_out_tvalid", out_tvalid, 0);
            check("rst_pixel_tready", pixel_tready, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_sync_error", sync_error, 0);
            check("rst_error_count", error_count, 0);
        end else begin
            exp_done = 0;
            exp_err  = 0;
            if (pop_prev && exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc_prev) model_accept(acc_data, acc_last);
            check("frame_done", frame_done, exp_done);
            check("sync_error", sync_error, exp_err);
            check("error_count", error_count, model_cnt);
            check("pixel_tready", pixel_tready, resync || exp_q.size() < 2);
            check("out_tvalid", out_tvalid, exp_q.size() != 0);
            if (out_tvalid && exp_q.size() != 0) begin
                check("out_tdata", out_tdata, exp_q[0].data);
                check("out_hcount", out_hcount, exp_q[0].h);
                check("out_vcount", out_vcount, exp_q[0].v);
                check("out_sof", out_sof, exp_q[0].sof);
                check("out_eol", out_eol, exp_q[0].eol);
                check("out_tlast", out_tlast, exp_q[0].last);
            end
            if (out_tvalid && out_tready) begin
                pix_t o;
                o.data = out_tdata;
                o.h    = out_hcount;
                o.v    = out_vcount;
                o.sof  = out_sof;
                o.eol  = out_eol;
                o.last = out_tlast;
                log_q.push_back(o);
            end
            done_seen += frame_done;
            serr_seen += sync_error;
            if (!pixel_tready) ready_low_cnt++;
            acc_prev = pixel_tvalid && pixel_tready;
            acc_data = pixel_tdata;
            acc_last = pixel_tlast;
            pop_prev = out_tvalid && out_tready;
        end
    end

    // Downstream ready pattern; a single process owns out_tready.
    int cyc = 0;
    int stall_start = -100;
    bit toggle = 0;
    bit hold_low = 0;

    initial begin
        out_tready = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (hold_low)                                          out_tready = 1'b0;
            else if (cyc >= stall_start && cyc < stall_start + 5)  out_tready = 1'b0;
            else if (toggle)                                       out_tready = cyc[0];
            else                                                   out_tready = 1'b1;
        end
    end

    task automatic send(input int d, input bit l);
        bit ok = 0;
        pixel_tdata  = 8'(d);
        pixel_tlast  = l;
        pixel_tvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_in);
            if (pixel_tready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk_in);
        #1;
        pixel_tvalid = 1'b0;
        pixel_tlast  = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk_in);
            if (!out_tvalid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #3 rst_in = 1'b1;
        @(posedge clk_in);
        #3 rst_in = 1'b0;
    endtask

    function automatic int encode(int d, int h, int v, bit s, bit e, bit l);
        return (d << 16) | (h << 8) | (v << 4) | (int'(s) << 2) | (int'(e) << 1) | int'(l);
    endfunction

    int log_base, done_base, serr_base, rlow_base;

    task automatic mark();
        log_base  = log_q.size();
        done_base = done_seen;
        serr_base = serr_seen;
        rlow_base = ready_low_cnt;
    endtask

    task automatic chk_log(input string name, input int idx, input int d, input int h, input int v,
                           input bit s, input bit e, input bit l);
        pix_t p;
        if (log_base + idx >= log_q.size()) begin
            check({name, "_missing"}, log_q.size(), log_base + idx + 1);
            return;
        end
        p = log_q[log_base + idx];
        check(name, encode(p.data, p.h, p.v, p.sof, p.eol, p.last), encode(d, h, v, s, e, l));
    endtask

    initial begin
        int junk;
        rst_in       = 1'b1;
        pixel_tvalid = 1'b0;
        pixel_tdata  = 8'h00;
        pixel_tlast  = 1'b0;
        repeat (2) @(posedge clk_in);
        #3 rst_in = 1'b0;

        // 1: clean frame, full throughput
        mark();
        check("t1_idle_tvalid", out_tvalid, 0);
        send(8'h00, 1'b0);
        check("t1_latency_tvalid", out_tvalid, 1);
        for (int i = 1; i < 8; i++) send(i, i == 7);
        drain();
        check("t1_count", log_q.size() - log_base, 8);
        chk_log("t1_px0", 0, 8'h00, 0, 0, 1, 0, 0);
        chk_log("t1_px3", 3, 8'h03, 3, 0, 0, 1, 0);
        chk_log("t1_px4", 4, 8'h04, 0, 1, 0, 0, 0);
        chk_log("t1_px7", 7, 8'h07, 3, 1, 0, 1, 1);
        check("t1_frame_done_pulses", done_seen - done_base, 1);
        check("t1_no_sync_error", serr_seen - serr_base, 0);

        // 2: toggling ready plus a 5-cycle stall
        mark();
        toggle      = 1;
        stall_start = cyc + 3;
        for (int i = 0; i < 8; i++) send(i, i == 7);
        drain();
        toggle = 0;
        check("t2_count", log_q.size() - log_base, 8);
        for (int i = 0; i < 8; i++) chk_log("t2_order", i, i, i % H, i / H, i == 0, i % H == H - 1, i == 7);
        check("t2_ready_dropped", ready_low_cnt - rlow_base > 0, 1);
        check("t2_frame_done_pulses", done_seen - done_base, 1);

        // 3: early tlast on the 5th pixel
        do_reset();
        mark();
        for (int i = 0; i < 5; i++) send(i, i == 4);
        for (int i = 0; i < 8; i++) send(8'h10 + i, i == 7);
        drain();
        chk_log("t3_early_last", 4, 8'h04, 0, 1, 0, 0, 1);
        chk_log("t3_restart", 5, 8'h10, 0, 0, 1, 0, 0);
        chk_log("t3_frame_end", 12, 8'h17, 3, 1, 0, 1, 1);
        check("t3_error_count", error_count, 1);
        check("t3_sync_pulses", serr_seen - serr_base, 1);
        check("t3_frame_done_pulses", done_seen - done_base, 1);

        // 4: late tlast, junk dropped, clean frame after
        do_reset();
        mark();
        for (int i = 0; i < 8; i++) send(8'h20 + i, 1'b0);
        for (int i = 0; i < 3; i++) send(8'hE0 + i, i == 2);
        for (int i = 0; i < 8; i++) send(8'h30 + i, i == 7);
        drain();
        check("t4_count", log_q.size() - log_base, 16);
        chk_log("t4_forced_last", 7, 8'h27, 3, 1, 0, 1, 1);
        chk_log("t4_clean_start", 8, 8'h30, 0, 0, 1, 0, 0);
        chk_log("t4_clean_end", 15, 8'h37, 3, 1, 0, 1, 1);
        junk = 0;
        for (int i = log_base; i < log_q.size(); i++)
            if (log_q[i].data >= 8'hE0 && log_q[i].data <= 8'hE2) junk++;
        check("t4_junk_absent", junk, 0);
        check("t4_error_count", error_count, 1);
        check("t4_frame_done_pulses", done_seen - done_base, 1);

        // 5: async reset with two pixels buffered
        do_reset();
        hold_low = 1;
        @(posedge clk_in);
        #1;
        send(8'h40, 1'b0);
        send(8'h41, 1'b0);
        check("t5_buffer_full_ready", pixel_tready, 0);
        #2 rst_in = 1'b1;
        #1;
        check("t5_async_tvalid", out_tvalid, 0);
        check("t5_reset_ready", pixel_tready, 0);
        @(posedge clk_in);
        #3 rst_in = 1'b0;
        hold_low = 0;
        mark();
        for (int i = 0; i < 8; i++) send(8'h50 + i, i == 7);
        drain();
        check("t5_count", log_q.size() - log_base, 8);
        chk_log("t5_first_after_reset", 0, 8'h50, 0, 0, 1, 0, 0);
        check("t5_frame_done_pulses", done_seen - done_base, 1);

        // 6: error_count saturation
        do_reset();
        for (int i = 0; i < 65534; i++) send(i, 1'b1);
        drain();
        check("t6_count_fffe", error_count, 16'hFFFE);
        mark();
        for (int i = 0; i < 3; i++) send(i, 1'b1);
        drain();
        check("t6_count_saturated", error_count, 16'hFFFF);
        check("t6_sync_pulses", serr_seen - serr_base, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
